// File: rtl/rca.sv
// ---------------------------------------------------------------------------
// rca -- parameterised ripple-carry adder with an optional registered output.
//
// The combinational path is a chain of SIZE one-bit full-adder cells.
// Cell 0 has a constant-zero carry-in, and each cell feeds its carry-out to
// the next cell. The carry-out of the top cell becomes result[SIZE].
//
// The registered path captures that sum into result_q on a rising clk edge
// whenever in_valid is high. out_valid marks the cycle that result_q holds a
// freshly captured sum.
//
// Parameters
//   SIZE      operand width in bits, 1..64
//
// Ports (declaration order is fixed so that a positional (a, b, result)
// hookup reaches the combinational adder)
//   a         in   SIZE    unsigned addend A
//   b         in   SIZE    unsigned addend B
//   result    out  SIZE+1  combinational sum, bit SIZE is the carry-out
//   clk       in   1       rising-edge clock, registered path only
//   rst_n     in   1       asynchronous active-low reset, registered path only
//   in_valid  in   1       qualifies a/b for capture into result_q
//   result_q  out  SIZE+1  registered copy of result
//   out_valid out  1       high while result_q holds a just-captured sum
// ---------------------------------------------------------------------------

// One-bit full-adder cell. The carry is written as generate/propagate
// (x AND y) OR (cin AND (x XOR y)), so the cell reads as one ripple stage.
module RcaFullAdder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic propagate;

   assign propagate = x ^ y;
   assign sum       = propagate ^ cin;
   assign cout      = (x & y) | (cin & propagate);

endmodule

module rca #(
   parameter int SIZE = 8
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE:0]   result,
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic [SIZE:0]   result_q,
   output logic            out_valid
);

   // carryChain[i] is the carry into cell i. carryChain[SIZE] is the final
   // carry-out of the chain.
   logic [SIZE:0]   carryChain;
   logic [SIZE-1:0] sumBits;
   logic [SIZE:0]   result_d;

   assign carryChain[0] = 1'b0;

   // Build the ripple chain one cell per bit. SIZE = 1 produces a single
   // cell, and its carry-out lands directly in result[1].
   for (genvar i = 0; i < SIZE; i++) begin : gCell
      RcaFullAdder uCell (
         .x    (a[i]),
         .y    (b[i]),
         .cin  (carryChain[i]),
         .sum  (sumBits[i]),
         .cout (carryChain[i+1])
      );
   end

   // The combinational sum never involves clk, rst_n or in_valid. It keeps
   // tracking a + b even while the registered path is held in reset.
   assign result = {carryChain[SIZE], sumBits};

   // Next-state for the capture register: load the live sum when in_valid
   // qualifies it, otherwise hold the last captured value.
   always_comb begin
      result_d = result_q;
      if (in_valid) begin
         result_d = result;
      end
   end

   // Capture register. Reset clears both outputs at once, without waiting
   // for a clock edge. This also discards a capture that was about to
   // happen, so no stale out_valid pulse appears after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q  <= '0;
         out_valid <= 1'b0;
      end else begin
         result_q  <= result_d;
         out_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_rca.sv
// ---------------------------------------------------------------------------
// tb_rca -- directed and random checks for the ripple-carry adder.
//
// Four instances (SIZE = 1, 4, 8, 16) share one clock and one reset.
// Most directed scenarios drive the SIZE=8 instance. The SIZE=1 instance
// covers the single-cell truth table. All four instances are exercised
// together in the random regression.
//
// Inputs change on the falling edge. Combinational results are sampled
// 1 time unit after an input change. Registered outputs are sampled
// 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rca;

   logic clk;
   logic rst_n;

   logic [0:0]  a1, b1;
   logic [1:0]  res1, resQ1;
   logic        inV1, outV1;

   logic [3:0]  a4, b4;
   logic [4:0]  res4, resQ4;
   logic        inV4, outV4;

   logic [7:0]  a8, b8;
   logic [8:0]  res8, resQ8;
   logic        inV8, outV8;

   logic [15:0] a16, b16;
   logic [16:0] res16, resQ16;
   logic        inV16, outV16;

   int checkCount;
   int errorCount;

   rca #(.SIZE(1)) dut1 (
      .a(a1), .b(b1), .result(res1), .clk(clk), .rst_n(rst_n),
      .in_valid(inV1), .result_q(resQ1), .out_valid(outV1)
   );

   rca #(.SIZE(4)) dut4 (
      .a(a4), .b(b4), .result(res4), .clk(clk), .rst_n(rst_n),
      .in_valid(inV4), .result_q(resQ4), .out_valid(outV4)
   );

   rca #(.SIZE(8)) dut8 (
      .a(a8), .b(b8), .result(res8), .clk(clk), .rst_n(rst_n),
      .in_valid(inV8), .result_q(resQ8), .out_valid(outV8)
   );

   rca #(.SIZE(16)) dut16 (
      .a(a16), .b(b16), .result(res16), .clk(clk), .rst_n(rst_n),
      .in_valid(inV16), .result_q(resQ16), .out_valid(outV16)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reset holds the outputs at zero, even across a clock edge with
   // in_valid high. The combinational sum keeps working during reset.
   // After release, the first qualified edge performs the first capture.
   task automatic test_reset();
      a8 = 8'h03; b8 = 8'h04; inV8 = 1'b0;
      #1;
      checkCount++;
      if (resQ8 !== 9'h000 || outV8 !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_state: result_q=%h out_valid=%b expected 000/0", resQ8, outV8);
      end
      checkCount++;
      if (res8 !== 9'h007) begin
         errorCount++;
         $display("[TB] FAIL reset_comb: result=%h expected 007", res8);
      end
      inV8 = 1'b1;
      @(posedge clk); #1;
      checkCount++;
      if (resQ8 !== 9'h000 || outV8 !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL reset_hold: result_q=%h out_valid=%b expected 000/0", resQ8, outV8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a8 = 8'h10; b8 = 8'h20; inV8 = 1'b1;
      @(posedge clk); #1;
      checkCount++;
      if (resQ8 !== 9'h030 || outV8 !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL first_capture: result_q=%h out_valid=%b expected 030/1", resQ8, outV8);
      end
      @(negedge clk);
      inV8 = 1'b0;
   endtask

   // Single-cell truth table, walking the pairs in the required order.
   task automatic test_size1();
      logic [1:0] vecAB  [8] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
      logic [1:0] expSum [8] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10};
      for (int i = 0; i < 8; i++) begin
         a1 = vecAB[i][1];
         b1 = vecAB[i][0];
         #1;
         checkCount++;
         if (res1 !== expSum[i]) begin
            errorCount++;
            $display("[TB] FAIL size1_vec%0d: result=%b expected %b", i, res1, expSum[i]);
         end
      end
   endtask

   // SIZE=8 corner sums, including a carry that ripples through all eight cells.
   task automatic test_edge_sums();
      logic [7:0] vecA [4] = '{8'h00, 8'hFF, 8'hFF, 8'hAA};
      logic [7:0] vecB [4] = '{8'h00, 8'h01, 8'hFF, 8'h55};
      logic [8:0] expS [4] = '{9'h000, 9'h100, 9'h1FE, 9'h0FF};
      for (int i = 0; i < 4; i++) begin
         a8 = vecA[i];
         b8 = vecB[i];
         #1;
         checkCount++;
         if (res8 !== expS[i]) begin
            errorCount++;
            $display("[TB] FAIL edge_sum%0d: result=%h expected %h", i, res8, expS[i]);
         end
      end
   endtask

   // Capture with in_valid high, then hold with in_valid low while the
   // operands change underneath.
   task automatic test_registered_path();
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h80; inV8 = 1'b1;
      @(posedge clk); #1;
      checkCount++;
      if (resQ8 !== 9'h100 || outV8 !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL reg_capture: result_q=%h out_valid=%b expected 100/1", resQ8, outV8);
      end
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h02; inV8 = 1'b0;
      @(posedge clk); #1;
      checkCount++;
      if (resQ8 !== 9'h100 || outV8 !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL reg_hold: result_q=%h out_valid=%b expected 100/0", resQ8, outV8);
      end
      checkCount++;
      if (res8 !== 9'h003) begin
         errorCount++;
         $display("[TB] FAIL reg_hold_comb: result=%h expected 003", res8);
      end
   endtask

   // Reset asserted between clock edges with result_q nonzero and a
   // capture pending. Outputs must clear before the next edge, and no
   // stale capture may appear after reset is released.
   task automatic test_async_reset();
      @(negedge clk);
      a8 = 8'h41; b8 = 8'h22; inV8 = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checkCount++;
      if (resQ8 !== 9'h000 || outV8 !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL async_clear: result_q=%h out_valid=%b expected 000/0", resQ8, outV8);
      end
      checkCount++;
      if (res8 !== 9'h063) begin
         errorCount++;
         $display("[TB] FAIL async_comb: result=%h expected 063", res8);
      end
      @(posedge clk);
      @(negedge clk);
      inV8 = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkCount++;
      if (resQ8 !== 9'h000 || outV8 !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL no_stale: result_q=%h out_valid=%b expected 000/0", resQ8, outV8);
      end
   endtask

   // Three captures on consecutive edges.
   task automatic test_back_to_back();
      logic [7:0] vecA [3] = '{8'h01, 8'h7F, 8'hF0};
      logic [7:0] vecB [3] = '{8'h02, 8'h01, 8'h0F};
      logic [8:0] expQ [3] = '{9'h003, 9'h080, 9'h0FF};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a8 = vecA[i]; b8 = vecB[i]; inV8 = 1'b1;
         @(posedge clk); #1;
         checkCount++;
         if (resQ8 !== expQ[i] || outV8 !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL b2b_%0d: result_q=%h out_valid=%b expected %h/1", i, resQ8, outV8, expQ[i]);
         end
      end
      @(negedge clk);
      inV8 = 1'b0;
   endtask

   // 1000 random operand pairs on all four widths, with a random in_valid.
   // The sum is checked combinationally, and a hold/capture model tracks
   // result_q and out_valid.
   task automatic test_random();
      logic [1:0]  mq1,  s1;
      logic [4:0]  mq4,  s4;
      logic [8:0]  mq8,  s8;
      logic [16:0] mq16, s16;
      logic        vld;
      @(negedge clk);
      inV1 = 1'b0; inV4 = 1'b0; inV8 = 1'b0; inV16 = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      mq1 = '0; mq4 = '0; mq8 = '0; mq16 = '0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a1  = 1'($urandom);  b1  = 1'($urandom);
         a4  = 4'($urandom);  b4  = 4'($urandom);
         a8  = 8'($urandom);  b8  = 8'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         vld = ($urandom_range(0, 3) != 0);
         inV1 = vld; inV4 = vld; inV8 = vld; inV16 = vld;
         s1  = 2'(a1)   + 2'(b1);
         s4  = 5'(a4)   + 5'(b4);
         s8  = 9'(a8)   + 9'(b8);
         s16 = 17'(a16) + 17'(b16);
         #1;
         checkCount++;
         if (res1 !== s1 || res4 !== s4 || res8 !== s8 || res16 !== s16) begin
            errorCount++;
            $display("[TB] FAIL rand_comb%0d: got %h %h %h %h expected %h %h %h %h",
                     i, res1, res4, res8, res16, s1, s4, s8, s16);
         end
         if (vld) begin
            mq1 = s1; mq4 = s4; mq8 = s8; mq16 = s16;
         end
         @(posedge clk); #1;
         checkCount++;
         if (resQ1 !== mq1 || resQ4 !== mq4 || resQ8 !== mq8 || resQ16 !== mq16) begin
            errorCount++;
            $display("[TB] FAIL rand_q%0d: got %h %h %h %h expected %h %h %h %h",
                     i, resQ1, resQ4, resQ8, resQ16, mq1, mq4, mq8, mq16);
         end
         checkCount++;
         if (outV1 !== vld || outV4 !== vld || outV8 !== vld || outV16 !== vld) begin
            errorCount++;
            $display("[TB] FAIL rand_valid%0d: got %b%b%b%b expected %b",
                     i, outV1, outV4, outV8, outV16, vld);
         end
      end
   endtask

   // Run every scenario in order, then print the summary.
   initial begin
      checkCount = 0;
      errorCount = 0;
      rst_n = 1'b0;
      a1 = '0; b1 = '0; inV1 = 1'b0;
      a4 = '0; b4 = '0; inV4 = 1'b0;
      a8 = '0; b8 = '0; inV8 = 1'b0;
      a16 = '0; b16 = '0; inV16 = 1'b0;
      $display("[TB] starting rca checks");
      test_reset();
      test_size1();
      test_edge_sums();
      test_registered_path();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
